cache_miss_controller: RTL and testbench

Request sequencer between the core's load/store port and the two-way LRU cache, with a single-word external memory port.
- Accepts one request at a time and performs the cache lookup.
- On a read miss, fetches the word from memory, refills the cache, then returns the data.
- Writes are write-through with write-allocate.
- Keeps saturating hit and miss counters for performance monitoring.

---
 rtl/cache_ctrl_pkg.sv | 16 +
 rtl/sat_counter.sv | 24 ++
 rtl/cache_miss_controller.sv | 160 ++++++++++++++++
 tb/tb_cache_miss_controller.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the cache miss controller.
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_RD,
        MEM_WAIT,
        FILL,
        MEM_WR,
        RESP
    } ctrl_state_t;

    localparam logic [31:0] COUNTER_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/sat_counter.sv
// 32-bit event counter that sticks at its maximum instead of wrapping.
module sat_counter
    import cache_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q;

    // Count one event per cycle while inc is high, holding at the top value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (inc && (count_q != COUNTER_MAX)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_miss_controller.sv
// Sequences one core load/store at a time through the cache, refilling from
// a single-word memory port on read misses and writing stores through.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | ready for a request
// LOOKUP   | cache probed with the latched address; stores write the cache
// MEM_RD   | read request presented to memory until accepted
// MEM_WAIT | waiting for the memory read response
// FILL     | refill data written into the cache
// MEM_WR   | posted write-through request presented until accepted
// RESP     | one-cycle completion pulse to the core
module cache_miss_controller
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [DATA_SIZE-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [DATA_SIZE-1:0] resp_rdata,
    output logic [ADDR_SIZE-1:0] cache_addr,
    output logic                 cache_write_enable,
    output logic [DATA_SIZE-1:0] cache_write_data,
    input  logic [DATA_SIZE-1:0] cache_read_data,
    input  logic                 cache_hit,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_we,
    output logic [ADDR_SIZE-1:0] mem_req_addr,
    output logic [DATA_SIZE-1:0] mem_req_wdata,
    input  logic                 mem_resp_valid,
    input  logic [DATA_SIZE-1:0] mem_resp_rdata,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);

    ctrl_state_t          state;
    logic [ADDR_SIZE-1:0] addr_q;
    logic                 we_q;
    logic [DATA_SIZE-1:0] wdata_q;
    logic [DATA_SIZE-1:0] rdata_q;
    logic                 hit_inc;
    logic                 miss_inc;

    // Stores that hit count as hits; only load misses count as misses.
    assign hit_inc  = (state == LOOKUP) && cache_hit;
    assign miss_inc = (state == LOOKUP) && !we_q && !cache_hit;

    // The latched request feeds both ports directly, so they are stable for
    // the whole transaction without extra registers.
    assign req_ready     = (state == IDLE);
    assign cache_addr    = addr_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_we    = we_q;
    assign mem_req_wdata = wdata_q;

    // Controller FSM; strobes are set on the edge entering the state that owns them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            addr_q             <= '0;
            we_q               <= 1'b0;
            wdata_q            <= '0;
            rdata_q            <= '0;
            resp_valid         <= 1'b0;
            resp_rdata         <= '0;
            cache_write_enable <= 1'b0;
            cache_write_data   <= '0;
            mem_req_valid      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q             <= req_addr;
                        we_q               <= req_we;
                        wdata_q            <= req_wdata;
                        cache_write_enable <= req_we;
                        cache_write_data   <= req_wdata;
                        state              <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    cache_write_enable <= 1'b0;
                    if (we_q) begin
                        mem_req_valid <= 1'b1;
                        state         <= MEM_WR;
                    end else if (cache_hit) begin
                        rdata_q    <= cache_read_data;
                        resp_valid <= 1'b1;
                        resp_rdata <= cache_read_data;
                        state      <= RESP;
                    end else begin
                        mem_req_valid <= 1'b1;
                        state         <= MEM_RD;
                    end
                end
                MEM_RD: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_resp_valid) begin
                        rdata_q            <= mem_resp_rdata;
                        cache_write_enable <= 1'b1;
                        cache_write_data   <= mem_resp_rdata;
                        state              <= FILL;
                    end
                end
                FILL: begin
                    cache_write_enable <= 1'b0;
                    resp_valid         <= 1'b1;
                    resp_rdata         <= rdata_q;
                    state              <= RESP;
                end
                MEM_WR: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        resp_valid    <= 1'b1;
                        resp_rdata    <= '0;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    cache_write_enable <= 1'b0;
                    mem_req_valid      <= 1'b0;
                    resp_valid         <= 1'b0;
                    state              <= IDLE;
                end
            endcase
        end
    end

    sat_counter u_hit_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter u_miss_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .count (miss_count)
    );

endmodule

// File: tb/tb_cache_miss_controller.sv
// Self-checking bench for cache_miss_controller with a cache/memory environment
// and a transaction-level reference model.
module tb_cache_miss_controller;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [31:0] cache_addr;
    logic        cache_write_enable;
    logic [31:0] cache_write_data;
    logic [31:0] cache_read_data;
    logic        cache_hit;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    cache_miss_controller #(.ADDR_SIZE(32), .DATA_SIZE(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_we             (req_we),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .resp_valid         (resp_valid),
        .resp_rdata         (resp_rdata),
        .cache_addr         (cache_addr),
        .cache_write_enable (cache_write_enable),
        .cache_write_data   (cache_write_data),
        .cache_read_data    (cache_read_data),
        .cache_hit          (cache_hit),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_we         (mem_req_we),
        .mem_req_addr       (mem_req_addr),
        .mem_req_wdata      (mem_req_wdata),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_rdata     (mem_resp_rdata),
        .hit_count          (hit_count),
        .miss_count         (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: cache contents driven by the DUT's writes, backing memory.
    logic [31:0] env_cache [logic [31:0]];
    logic [31:0] env_mem   [logic [31:0]];
    // Reference model state.
    logic [31:0] ref_cache [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] ref_hits;
    logic [31:0] ref_misses;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    always @(posedge clk) begin
        if (rst && cache_write_enable) env_cache[cache_addr] = cache_write_data;
    end

    initial begin
        cache_hit       = 1'b0;
        cache_read_data = 32'hBAD0_BAD0;
    end

    always @(negedge clk) begin
        if (env_cache.exists(cache_addr)) begin
            cache_hit       = 1'b1;
            cache_read_data = env_cache[cache_addr];
        end else begin
            cache_hit       = 1'b0;
            cache_read_data = 32'hBAD0_BAD0;
        end
    end

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        int          n_hs;
        bit          stable_ok;
        logic [31:0] maddr;
        logic        mwe;
        logic [31:0] mwdata;
        int          cw_count;
        logic [31:0] cw_addr;
        logic [31:0] cw_data;
        int          cw_cycle;
        bit          ready_ok;
        bit          extra;
    } txn_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        int          n_hs;
        int          cw_count;
        logic [31:0] cw_data;
        int          cw_cycle;
    } exp_t;

    // Drive one request and play the memory side; reports what was observed.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int ready_wait, input int resp_wait, input bit stray,
                           output txn_t t);
        int  c;
        int  waited;
        int  hs_cycle;
        bit  hs_done;
        bit  hs_we;
        bit  first;
        t = '{lat: -1, rdata: 32'h0, n_hs: 0, stable_ok: 1'b1, maddr: 32'h0, mwe: 1'b0,
              mwdata: 32'h0, cw_count: 0, cw_addr: 32'h0, cw_data: 32'h0, cw_cycle: -1,
              ready_ok: 1'b0, extra: 1'b0};
        waited = 0; hs_cycle = -1; hs_done = 1'b0; hs_we = 1'b0; first = 1'b1;
        @(negedge clk);
        t.ready_ok = req_ready;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
        c = 1;
        while (c < 100) begin
            mem_resp_valid = 1'b0;
            if (resp_valid) begin
                t.lat   = c;
                t.rdata = resp_rdata;
                break;
            end
            if (stray && c == 1) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = 32'hCAFE_0001;
            end
            if (hs_done && !hs_we && c == hs_cycle + resp_wait) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = env_mem.exists(addr) ? env_mem[addr] : mem_init(addr);
            end
            if (cache_write_enable) begin
                t.cw_count++;
                t.cw_addr  = cache_addr;
                t.cw_data  = cache_write_data;
                t.cw_cycle = c;
            end
            if (mem_req_valid) begin
                if (first) begin
                    first    = 1'b0;
                    t.maddr  = mem_req_addr;
                    t.mwe    = mem_req_we;
                    t.mwdata = mem_req_wdata;
                end else if (mem_req_addr !== t.maddr || mem_req_we !== t.mwe ||
                             (t.mwe && mem_req_wdata !== t.mwdata)) begin
                    t.stable_ok = 1'b0;
                end
                if (waited >= ready_wait) begin
                    mem_req_ready = 1'b1;
                    hs_done  = 1'b1;
                    hs_cycle = c;
                    hs_we    = mem_req_we;
                    t.n_hs++;
                    if (mem_req_we) env_mem[mem_req_addr] = mem_req_wdata;
                    if (stray) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_rdata = 32'hCAFE_0002;
                    end
                end else begin
                    mem_req_ready = 1'b0;
                end
                waited++;
            end else begin
                mem_req_ready = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        @(negedge clk);
        t.extra = resp_valid;
    endtask

    // Reference model: what a transaction must produce, from the block's rules.
    task automatic model_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input int ready_wait, input int resp_wait, output exp_t e);
        bit hit;
        hit = ref_cache.exists(addr);
        e = '{lat: 0, rdata: 32'h0, n_hs: 0, cw_count: 0, cw_data: 32'h0, cw_cycle: -1};
        if (we) begin
            if (hit && ref_hits != 32'hFFFF_FFFF) ref_hits++;
            ref_cache[addr] = wdata;
            ref_mem[addr]   = wdata;
            e.lat = 3 + ready_wait;
            e.n_hs = 1; e.cw_count = 1; e.cw_data = wdata; e.cw_cycle = 1;
        end else if (hit) begin
            if (ref_hits != 32'hFFFF_FFFF) ref_hits++;
            e.lat = 2;
            e.rdata = ref_cache[addr];
        end else begin
            if (ref_misses != 32'hFFFF_FFFF) ref_misses++;
            e.rdata = ref_mem.exists(addr) ? ref_mem[addr] : mem_init(addr);
            ref_cache[addr] = e.rdata;
            e.lat = 4 + ready_wait + resp_wait;
            e.n_hs = 1; e.cw_count = 1; e.cw_data = e.rdata; e.cw_cycle = 3 + ready_wait + resp_wait;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        ref_hits = '0; ref_misses = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        n_checks++;
        if ({resp_valid, mem_req_valid, cache_write_enable} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 000", {resp_valid, mem_req_valid, cache_write_enable});
        end
        n_checks++;
        if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
            n_fail++; $display("FAIL reset_counters: got hit=%0h miss=%0h expected 0/0", hit_count, miss_count);
        end
    endtask

    task automatic test_store();
        txn_t t; exp_t e;
        model_txn(1'b1, 32'h40, 32'hDEAD_BEEF, 0, 0, e);
        run_txn(1'b1, 32'h40, 32'hDEAD_BEEF, 0, 0, 1'b0, t);
        n_checks++;
        if (t.cw_count !== 1 || t.cw_cycle !== 1 || t.cw_data !== 32'hDEAD_BEEF || t.cw_addr !== 32'h40) begin
            n_fail++; $display("FAIL store_cache_write: got n=%0d cyc=%0d a=%0h d=%0h expected 1/1/40/deadbeef",
                               t.cw_count, t.cw_cycle, t.cw_addr, t.cw_data);
        end
        n_checks++;
        if (t.n_hs !== 1 || t.maddr !== 32'h40 || t.mwe !== 1'b1 || t.mwdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL store_mem_write: got n=%0d a=%0h we=%b d=%0h expected 1/40/1/deadbeef",
                               t.n_hs, t.maddr, t.mwe, t.mwdata);
        end
        n_checks++;
        if (t.lat !== 3 || t.rdata !== 32'h0) begin
            n_fail++; $display("FAIL store_resp: got lat=%0d rdata=%0h expected 3/0", t.lat, t.rdata);
        end
        n_checks++;
        if (miss_count !== 32'h0 || hit_count !== 32'h0) begin
            n_fail++; $display("FAIL store_counters: got hit=%0h miss=%0h expected 0/0", hit_count, miss_count);
        end
    endtask

    task automatic test_load_hit();
        txn_t t; exp_t e;
        model_txn(1'b0, 32'h40, 32'h0, 0, 0, e);
        run_txn(1'b0, 32'h40, 32'h0, 0, 0, 1'b0, t);
        n_checks++;
        if (t.lat !== 2 || t.rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL hit_resp: got lat=%0d rdata=%0h expected 2/deadbeef", t.lat, t.rdata);
        end
        n_checks++;
        if (t.n_hs !== 0 || t.cw_count !== 0) begin
            n_fail++; $display("FAIL hit_no_mem: got mem_hs=%0d cache_writes=%0d expected 0/0", t.n_hs, t.cw_count);
        end
        n_checks++;
        if (hit_count !== 32'h1 || miss_count !== 32'h0) begin
            n_fail++; $display("FAIL hit_counters: got hit=%0h miss=%0h expected 1/0", hit_count, miss_count);
        end
        n_checks++;
        if (t.extra !== 1'b0 || t.ready_ok !== 1'b1) begin
            n_fail++; $display("FAIL hit_pulse: got extra=%b ready=%b expected 0/1", t.extra, t.ready_ok);
        end
    endtask

    task automatic test_load_miss();
        txn_t t; exp_t e;
        env_mem[32'h80] = 32'h1234_5678;
        ref_mem[32'h80] = 32'h1234_5678;
        model_txn(1'b0, 32'h80, 32'h0, 3, 5, e);
        run_txn(1'b0, 32'h80, 32'h0, 3, 5, 1'b1, t);
        n_checks++;
        if (t.stable_ok !== 1'b1 || t.n_hs !== 1 || t.maddr !== 32'h80 || t.mwe !== 1'b0) begin
            n_fail++; $display("FAIL miss_mem_req: got stable=%b n=%0d a=%0h we=%b expected 1/1/80/0",
                               t.stable_ok, t.n_hs, t.maddr, t.mwe);
        end
        n_checks++;
        if (t.cw_count !== 1 || t.cw_addr !== 32'h80 || t.cw_data !== 32'h1234_5678 || t.cw_cycle !== 11) begin
            n_fail++; $display("FAIL miss_fill: got n=%0d a=%0h d=%0h cyc=%0d expected 1/80/12345678/11",
                               t.cw_count, t.cw_addr, t.cw_data, t.cw_cycle);
        end
        n_checks++;
        if (t.lat !== 12 || t.rdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL miss_resp: got lat=%0d rdata=%0h expected 12/12345678", t.lat, t.rdata);
        end
        n_checks++;
        if (miss_count !== 32'h1 || hit_count !== 32'h1) begin
            n_fail++; $display("FAIL miss_counters: got hit=%0h miss=%0h expected 1/1", hit_count, miss_count);
        end
    endtask

    task automatic test_reset_midflight();
        txn_t t; exp_t e;
        bit saw_resp;
        bit saw_cw;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h300;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_mem_rd: got %b expected 1", mem_req_valid); end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, resp_valid, mem_req_valid, cache_write_enable} !== 4'b1000 || miss_count !== 32'h0) begin
            n_fail++; $display("FAIL midrst_state: got rdy/rv/mv/cw=%b miss=%0h expected 1000/0",
                               {req_ready, resp_valid, mem_req_valid, cache_write_enable}, miss_count);
        end
        ref_hits = '0; ref_misses = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h5555_AAAA;
        saw_resp = 1'b0; saw_cw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (resp_valid) saw_resp = 1'b1;
            if (cache_write_enable) saw_cw = 1'b1;
        end
        n_checks++;
        if (saw_resp !== 1'b0 || saw_cw !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_stray: got resp=%b cw=%b ready=%b expected 0/0/1", saw_resp, saw_cw, req_ready);
        end
        model_txn(1'b0, 32'h300, 32'h0, 1, 2, e);
        run_txn(1'b0, 32'h300, 32'h0, 1, 2, 1'b0, t);
        n_checks++;
        if (t.lat !== e.lat || t.rdata !== e.rdata || miss_count !== ref_misses || hit_count !== ref_hits) begin
            n_fail++; $display("FAIL midrst_next_load: got lat=%0d rdata=%0h miss=%0h hit=%0h expected %0d/%0h/%0h/%0h",
                               t.lat, t.rdata, miss_count, hit_count, e.lat, e.rdata, ref_misses, ref_hits);
        end
    endtask

    task automatic test_random();
        txn_t t; exp_t e;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rw;
        int          d;
        bit          stray;
        for (int i = 0; i < 40; i++) begin
            we    = $urandom_range(0, 2) == 0;
            addr  = 32'h100 + 32'(4 * $urandom_range(0, 11));
            wdata = $urandom;
            rw    = $urandom_range(0, 3);
            d     = $urandom_range(1, 4);
            stray = $urandom_range(0, 1) == 1;
            model_txn(we, addr, wdata, rw, d, e);
            run_txn(we, addr, wdata, rw, d, stray, t);
            n_checks++;
            if (t.lat !== e.lat || t.rdata !== e.rdata) begin
                n_fail++; $display("FAIL rnd_resp[%0d]: got lat=%0d rdata=%0h expected %0d/%0h", i, t.lat, t.rdata, e.lat, e.rdata);
            end
            n_checks++;
            if (t.cw_count !== e.cw_count || t.cw_cycle !== e.cw_cycle ||
                (e.cw_count == 1 && (t.cw_data !== e.cw_data || t.cw_addr !== addr))) begin
                n_fail++; $display("FAIL rnd_cache_write[%0d]: got n=%0d cyc=%0d a=%0h d=%0h expected %0d/%0d/%0h/%0h",
                                   i, t.cw_count, t.cw_cycle, t.cw_addr, t.cw_data, e.cw_count, e.cw_cycle, addr, e.cw_data);
            end
            n_checks++;
            if (t.n_hs !== e.n_hs || !t.stable_ok ||
                (e.n_hs == 1 && (t.maddr !== addr || t.mwe !== we || (we && t.mwdata !== wdata)))) begin
                n_fail++; $display("FAIL rnd_mem_req[%0d]: got n=%0d stable=%b a=%0h we=%b d=%0h expected %0d/1/%0h/%b/%0h",
                                   i, t.n_hs, t.stable_ok, t.maddr, t.mwe, t.mwdata, e.n_hs, addr, we, wdata);
            end
            n_checks++;
            if (hit_count !== ref_hits || miss_count !== ref_misses) begin
                n_fail++; $display("FAIL rnd_counters[%0d]: got hit=%0h miss=%0h expected %0h/%0h",
                                   i, hit_count, miss_count, ref_hits, ref_misses);
            end
        end
    endtask

    task automatic test_back_to_back();
        txn_t t; exp_t e;
        for (int i = 0; i < 4; i++) begin
            model_txn(1'b0, 32'h40, 32'h0, 0, 0, e);
            run_txn(1'b0, 32'h40, 32'h0, 0, 0, 1'b0, t);
            n_checks++;
            if (t.ready_ok !== 1'b1 || t.lat !== 2 || t.rdata !== e.rdata || hit_count !== ref_hits) begin
                n_fail++; $display("FAIL b2b[%0d]: got ready=%b lat=%0d rdata=%0h hit=%0h expected 1/2/%0h/%0h",
                                   i, t.ready_ok, t.lat, t.rdata, hit_count, e.rdata, ref_hits);
            end
        end
    endtask

    task automatic test_saturation();
        txn_t t; exp_t e;
        @(negedge clk);
        force dut.u_hit_count.count_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_hit_count.count_q;
        ref_hits = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            model_txn(1'b0, 32'h40, 32'h0, 0, 0, e);
            run_txn(1'b0, 32'h40, 32'h0, 0, 0, 1'b0, t);
            n_checks++;
            if (hit_count !== ref_hits || t.rdata !== e.rdata) begin
                n_fail++; $display("FAIL sat_hit[%0d]: got hit=%0h rdata=%0h expected %0h/%0h",
                                   i, hit_count, t.rdata, ref_hits, e.rdata);
            end
        end
        n_checks++;
        if (hit_count !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL sat_final: got %0h expected ffffffff", hit_count);
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_hit();
        test_load_miss();
        test_reset_midflight();
        test_random();
        test_back_to_back();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
